// File: rtl/mem_responder.sv
// mem_responder: request/ready memory responder for the multicycle MIPS
// datapath. Unified word array, configurable wait states, registered read
// data, big-endian sign-extended byte reads and an illegal-access flag.
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        lb,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state, state_next;
    logic [3:0]    cnt;
    logic [AW+1:0] addr_q;
    logic          we_q, lb_q;
    logic [31:0]   wd_q;
    logic [31:0]   rd_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW+1:0] a_addr;
    logic          a_we, a_lb;
    logic [31:0]   a_wd;
    logic [AW-1:0] idx;
    logic          commit, acc_err;
    logic [31:0]   word, rd_next;
    logic [7:0]    byte_sel;

    // Upper address bits only alias; they never select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW+2];

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req) state_next = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
            S_WAIT:  if (cnt == 4'd1) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // With zero wait states the commit edge is also the accept edge, so the
    // access operands come straight from the inputs while in IDLE.
    always_comb begin
        a_addr   = (state == S_IDLE) ? addr[AW+1:0] : addr_q;
        a_we     = (state == S_IDLE) ? we : we_q;
        a_lb     = (state == S_IDLE) ? lb : lb_q;
        a_wd     = (state == S_IDLE) ? wd : wd_q;
        idx      = a_addr[AW+1:2];
        commit   = (state != S_DONE) && (state_next == S_DONE);
        acc_err  = (a_lb && a_we) || (!a_lb && (a_addr[1:0] != 2'b00));
        word     = mem[idx];
        byte_sel = 8'h00;
        case (a_addr[1:0])
            2'b00: byte_sel = word[31:24];
            2'b01: byte_sel = word[23:16];
            2'b10: byte_sel = word[15:8];
            2'b11: byte_sel = word[7:0];
            default: byte_sel = 8'h00;
        endcase
        if (acc_err || a_we) rd_next = '0;
        else if (a_lb)       rd_next = {{24{byte_sel[7]}}, byte_sel};
        else                 rd_next = word;
    end

    // State, wait counter, request latch and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            lb_q   <= 1'b0;
            wd_q   <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && req) begin
                cnt    <= 4'(WAIT_STATES);
                addr_q <= addr[AW+1:0];
                we_q   <= we;
                lb_q   <= lb;
                wd_q   <= wd;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rd_q  <= rd_next;
                err_q <= acc_err;
            end
        end
    end

    // Array write on the commit edge; gated by reset so a zero-wait write
    // presented while reset is held cannot land.
    always_ff @(posedge clk) begin
        if (reset && commit && a_we && !acc_err)
            mem[idx] <= a_wd;
    end

    assign rd    = rd_q;
    assign ready = (state == S_DONE);
    assign busy  = (state != S_IDLE);
    assign err   = (state == S_DONE) && err_q;

endmodule
